alu_result_blinker: RTL and testbench

- Downstream consumer of the 8-bit ALU result on the Pynq Z1 board.
- Captures one result ({Cout, Y[7:0]}) on a valid/ready handshake.
- Replays the 9 bits on a single LED as a human-readable pulse-width code, Cout first, then Y[7] down to Y[0], followed by an inter-frame gap.
- Replaces the "LSB only" LED hookup so the whole sum is visible on LED0.

---
 rtl/alu_result_blinker.sv | 100 ++++++++++
 tb/tb_alu_result_blinker.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_result_blinker.sv
// alu_result_blinker: captures one ALU result {Cout, Y} on a handshake and replays it on an LED as a pulse-width code
module alu_result_blinker #(
   parameter int CLKS_PER_TICK = 25_000_000,
   parameter int GAP_TICKS     = 8
) (
   input  logic       CLK_100MHZ,
   input  logic       BTN0,
   input  logic [7:0] res_y,
   input  logic       res_cout,
   input  logic       res_valid,
   output logic       ready,
   output logic       led,
   output logic       done,
   output logic       overrun
);
   localparam int TW = $clog2(CLKS_PER_TICK);
   localparam int GW = $clog2(GAP_TICKS + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);
   typedef enum logic [1:0] {IDLE, BIT, GAP} state_t;
   state_t        state_q;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [1:0]    slot_q;
   logic [3:0]    bit_idx_q;
   logic [GW-1:0] gap_q;
   logic [8:0]    shift_q;
   logic          ready_q, led_q, done_q, overrun_q;
   logic          tick;
   assign tick    = (tick_cnt_q == TICK_LAST);
   assign ready   = ready_q;
   assign led     = led_q;
   assign done    = done_q;
   assign overrun = overrun_q;
   // tick counter is parked at 0 while idle and wraps each tick during a frame
   always_comb begin
      tick_cnt_d = (state_q == IDLE || tick) ? '0 : tick_cnt_q + 1'b1;
   end
   // frame sequencer: handshake capture, 4-tick bit slots, trailing gap, registered outputs
   always_ff @(posedge CLK_100MHZ or negedge BTN0) begin
      if (!BTN0) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         slot_q     <= '0;
         bit_idx_q  <= '0;
         gap_q      <= '0;
         shift_q    <= '0;
         ready_q    <= 1'b1;
         led_q      <= 1'b0;
         done_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         done_q     <= 1'b0;
         overrun_q  <= res_valid && !ready_q;
         case (state_q)
            IDLE: begin
               if (res_valid && ready_q) begin
                  state_q   <= BIT;
                  shift_q   <= {res_cout, res_y};
                  bit_idx_q <= '0;
                  slot_q    <= '0;
                  ready_q   <= 1'b0;
                  led_q     <= 1'b1;
               end
            end
            BIT: begin
               if (tick) begin
                  if (slot_q == 2'd3) begin
                     if (bit_idx_q < 4'd8) begin
                        bit_idx_q <= bit_idx_q + 1'b1;
                        shift_q   <= {shift_q[7:0], 1'b0};
                        slot_q    <= '0;
                        led_q     <= 1'b1;
                     end else begin
                        state_q <= GAP;
                        led_q   <= 1'b0;
                        gap_q   <= '0;
                     end
                  end else begin
                     slot_q <= slot_q + 1'b1;
                     led_q  <= shift_q[8] && (slot_q != 2'd2);
                  end
               end
            end
            GAP: begin
               if (tick) begin
                  if (gap_q == GAP_LAST) begin
                     state_q <= IDLE;
                     ready_q <= 1'b1;
                     done_q  <= 1'b1;
                  end else begin
                     gap_q <= gap_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_result_blinker.sv
// tb_alu_result_blinker: directed vector bench for the LED pulse-width replay of ALU results
module tb_alu_result_blinker;
   localparam int CPT   = 4;
   localparam int GT    = 2;
   localparam int FRAME = 152;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] res_y = 8'h00;
   logic       res_cout = 1'b0;
   logic       res_valid = 1'b0;
   logic       ready, led, done, overrun;
   int         n_cmp = 0;
   int         n_bad = 0;

   typedef struct {
      string      name;
      logic [7:0] y;
      logic       cout;
      logic [7:0] y_after;
      int         ov_start;
      int         ov_len;
      int         ov_exp;
      int         hi[9];
   } vec_t;
   vec_t tbl[3];
   vec_t hv;

   alu_result_blinker #(.CLKS_PER_TICK(CPT), .GAP_TICKS(GT)) dut (
      .CLK_100MHZ(clk),
      .BTN0(rst_n),
      .res_y(res_y),
      .res_cout(res_cout),
      .res_valid(res_valid),
      .ready(ready),
      .led(led),
      .done(done),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic accept(input string nm, input logic [7:0] y, input logic c, input logic hold);
      res_y     = y;
      res_cout  = c;
      res_valid = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) res_valid = 1'b0;
      chk({nm, "_accept_ready"}, ready, 0);
      chk({nm, "_accept_led"}, led, 1);
   endtask

   task automatic frame(input vec_t v);
      int hi[9] = '{default: 0};
      int gap_hi = 0;
      int ov = 0;
      int dn = 0;
      for (int c = 0; c < FRAME; c++) begin
         if (led) begin
            if (c < 144) hi[c / 16]++;
            else gap_hi++;
         end
         ov += int'(overrun);
         dn += int'(done);
         if (c == 0) res_y = v.y_after;
         if (v.ov_len > 0 && c == v.ov_start) res_valid = 1'b1;
         if (v.ov_len > 0 && c == v.ov_start + v.ov_len) res_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      for (int s = 0; s < 9; s++) chk($sformatf("%s_slot%0d_hi", v.name, s), hi[s], v.hi[s]);
      chk({v.name, "_gap_led"}, gap_hi, 0);
      chk({v.name, "_overrun_cycles"}, ov, v.ov_exp);
      chk({v.name, "_early_done"}, dn, 0);
      chk({v.name, "_done_end"}, done, 1);
      chk({v.name, "_ready_end"}, ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int bad;
      tbl[0].name = "y08";   tbl[0].y = 8'h08; tbl[0].cout = 1'b0; tbl[0].y_after = 8'h08;
      tbl[0].ov_start = 0;   tbl[0].ov_len = 0; tbl[0].ov_exp = 0;
      tbl[0].hi = '{4, 4, 4, 4, 4, 12, 4, 4, 4};
      tbl[1].name = "y0F";   tbl[1].y = 8'h0F; tbl[1].cout = 1'b0; tbl[1].y_after = 8'hFF;
      tbl[1].ov_start = 0;   tbl[1].ov_len = 0; tbl[1].ov_exp = 0;
      tbl[1].hi = '{4, 4, 4, 4, 4, 12, 12, 12, 12};
      tbl[2].name = "yFFc1"; tbl[2].y = 8'hFF; tbl[2].cout = 1'b1; tbl[2].y_after = 8'hFF;
      tbl[2].ov_start = 40;  tbl[2].ov_len = 3; tbl[2].ov_exp = 3;
      tbl[2].hi = '{12, 12, 12, 12, 12, 12, 12, 12, 12};
      hv.name = "hold10"; hv.y = 8'h10; hv.cout = 1'b0; hv.y_after = 8'h10;
      hv.ov_start = 0;    hv.ov_len = 0; hv.ov_exp = 151;
      hv.hi = '{4, 4, 4, 4, 12, 4, 4, 4, 4};

      #12;
      chk("rst_ready", ready, 1);
      chk("rst_led", led, 0);
      chk("rst_done", done, 0);
      chk("rst_overrun", overrun, 0);
      #11 rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (ready !== 1'b1 || led !== 1'b0 || done !== 1'b0 || dut.tick_cnt_q !== '0) bad++;
      end
      chk("idle_50_cycles_bad", bad, 0);

      for (int i = 0; i < 3; i++) begin
         accept(tbl[i].name, tbl[i].y, tbl[i].cout, 1'b0);
         frame(tbl[i]);
         @(posedge clk);
         #1;
         chk({tbl[i].name, "_done_single"}, done, 0);
         chk({tbl[i].name, "_idle_ready"}, ready, 1);
      end

      accept("hold_first", 8'h10, 1'b0, 1'b1);
      frame(hv);
      @(posedge clk);
      #1;
      chk("hold_reaccept_ready", ready, 0);
      chk("hold_reaccept_led", led, 1);
      chk("hold_reaccept_done", done, 0);
      frame(hv);
      res_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("hold_release_ready", ready, 1);

      accept("abort", 8'hFF, 1'b1, 1'b0);
      repeat (70) @(posedge clk);
      #1;
      chk("abort_led_before", led, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_async_led", led, 0);
      chk("abort_async_ready", ready, 1);
      chk("abort_async_done", done, 0);
      #3 rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (led !== 1'b0 || ready !== 1'b1 || done !== 1'b0) bad++;
      end
      chk("abort_no_resume_bad", bad, 0);
      accept(tbl[0].name, tbl[0].y, tbl[0].cout, 1'b0);
      frame(tbl[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
